// File: rtl/aes_pkg.sv
// Shared AES definitions: key-expansion FSM states, field constants and
// the GF(2^8) doubling helper used by both the rcon sequence and the S-box.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } kexp_state_e;

  localparam int         NR_AES128     = 10;
  localparam logic [7:0] RCON_INIT     = 8'h01;
  localparam logic [7:0] GF_POLY       = 8'h1B;
  localparam logic [7:0] SBOX_AFFINE_C = 8'h63;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    logic [7:0] r;
    r = {b[6:0], 1'b0};
    if (b[7]) begin
      r = r ^ GF_POLY;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box computed algebraically: multiplicative inverse
// (a^254, so 0 maps to 0) followed by the affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  // Shift-and-add field multiply built on the shared doubling helper.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] bb;
    p  = 8'h00;
    x  = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) begin
        p = p ^ x;
      end else begin
        p = p;
      end
      x  = gf_xtime(x);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // a^254 = a^2 * a^4 * ... * a^128, formed by repeated squaring.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] inv_d;

  // Inverse then affine map: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  always_comb begin
    inv_d  = gf_inv(data_i);
    data_o = inv_d
           ^ {inv_d[6:0], inv_d[7]}
           ^ {inv_d[5:0], inv_d[7:6]}
           ^ {inv_d[4:0], inv_d[7:5]}
           ^ {inv_d[3:0], inv_d[7:4]}
           ^ SBOX_AFFINE_C;
  end

endmodule

// File: rtl/aes_key_expand_fwd.sv
// AES-128 forward key expansion. Emits round keys 0..NR one at a time over
// a valid/ready handshake, holding only the current round key in storage.
module aes_key_expand_fwd
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [127:0] key_i,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_idx_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  kexp_state_e  state_q;
  logic [127:0] key_q;
  logic [3:0]   idx_q;
  logic [7:0]   rcon_q;
  logic         valid_q;
  logic         busy_q;
  logic         done_q;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  t_word;
  logic [127:0] key_d;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  assign rot_word = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .data_i(rot_word[8*g +: 8]),
      .data_o(sub_word[8*g +: 8])
    );
  end

  // Next round key from the current one and the current rcon.
  always_comb begin
    logic [31:0] n0, n1, n2, n3;
    t_word = sub_word ^ {rcon_q, 24'h000000};
    n0     = w0 ^ t_word;
    n1     = w1 ^ n0;
    n2     = w2 ^ n1;
    n3     = w3 ^ n2;
    key_d  = {n0, n1, n2, n3};
  end

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= 128'h0;
      idx_q   <= 4'd0;
      rcon_q  <= RCON_INIT;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            key_q   <= key_i;
            idx_q   <= 4'd0;
            rcon_q  <= RCON_INIT;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_EMIT;
          end else begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        ST_EMIT: begin
          if (rk_ready_i) begin
            if (idx_q == LAST_IDX) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              key_q  <= key_d;
              idx_q  <= idx_q + 4'd1;
              rcon_q <= gf_xtime(rcon_q);
            end
          end else begin
            valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rk_o       = key_q;
  assign rk_idx_o   = idx_q;
  assign rk_valid_o = valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: doc/aes_key_expand_fwd.md
AES_KEY_EXPAND_FWD -- requirements
Module: aes_key_expand_fwd

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES-128 rounds; the only supported value is 10.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start_i  input  1  request to begin an expansion; sampled only in IDLE.
REQ-005 SHALL have port key_i  input  128  cipher key, byte 0 in bits [127:120]; captured when start_i is accepted.
REQ-006 SHALL have port rk_valid_o  output  1  rk_o/rk_idx_o hold a valid round key.
REQ-007 SHALL have port rk_ready_i  input  1  consumer accepts the round key.
REQ-008 SHALL have port rk_o  output  128  current round key w[4i..4i+3], w[4i] in bits [127:96].
REQ-009 SHALL have port rk_idx_o  output  4  round index i, 0..NR.
REQ-010 SHALL have port busy_o  output  1  high in every state other than IDLE.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse after round key NR is accepted.

Function
REQ-012 SHALL implement the FSM states IDLE, EMIT and DONE.
REQ-013 SHALL, in IDLE with start_i=1, load key_i into the key register, set the index to 0 and the rcon register to 0x01, and enter EMIT on the next edge.
REQ-014 SHALL ignore start_i in EMIT and DONE, with no effect on the key, index or outputs.
REQ-015 SHALL drive rk_valid_o=1 throughout EMIT, with rk_o equal to the key register and rk_idx_o equal to the index register.
REQ-016 SHALL keep rk_o, rk_idx_o and rk_valid_o stable while rk_valid_o=1 and rk_ready_i=0 (back-pressure for any number of cycles).
REQ-017 SHALL treat a cycle with rk_valid_o=1 and rk_ready_i=1 as a handshake; if the index < NR on a handshake, it SHALL load the next round key and index+1, remaining in EMIT.
REQ-018 SHALL, with rk_ready_i held high, present round keys 0..NR on 11 consecutive cycles, one per cycle and with no bubbles.
REQ-019 SHALL compute the next key as: t = SubWord(RotWord(w3)) XOR {rcon,00,00,00}; w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
REQ-020 SHALL step rcon through 01,02,04,08,10,20,40,80,1B,36 using GF(2^8) doubling (shift left, XOR 0x1B when bit 7 was set).
REQ-021 SHALL go to DONE on the handshake where index == NR, and assert done_o=1 for exactly that DONE cycle, then return to IDLE.
REQ-022 SHALL hold rk_valid_o=0 in IDLE and DONE.
REQ-023 SHALL accept a start_i that is high in the first IDLE cycle after DONE.
REQ-024 SHALL use the key register as the only 128-bit storage; no round-key array.

Reset
REQ-025 SHALL, on rst_n low, force state=IDLE, key register=0, index=0 and rcon=0x01, immediately and independent of clk.
REQ-026 SHALL drive these outputs in reset: rk_valid_o=0, busy_o=0, done_o=0, rk_o=0, rk_idx_o=0.
REQ-027 SHALL, on reset asserted mid-expansion, abandon the expansion with no done_o pulse; after release it SHALL wait in IDLE for a new start_i.

Structure
REQ-028 SHALL take the state enum, RCON_INIT (0x01), the reduction constant 0x1B and NR_AES128 (10) from the shared package aes_pkg.
REQ-029 SHALL instantiate four copies of the combinational forward S-box sub-module aes_sbox (8-bit in, 8-bit out) for SubWord; this is the forward counterpart of the decryption-side inverse S-box.
REQ-030 SHALL contain no latches; the rcon update SHALL share a gf_xtime function declared in aes_pkg.

Verification
REQ-031 SHALL check: key 2b7e151628aed2a6abf7158809cf4f3c, start, ready=1 -> idx0 = key; idx1 = a0fafe1788542cb123a339392a6c7605; idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done_o one cycle later.
REQ-032 SHALL check: all-zero key -> idx1 = 62636363626363636263636362636363.
REQ-033 SHALL check: rk_ready_i low for 5 cycles at idx3 -> rk_o/rk_idx_o unchanged for all 5 cycles, and idx4 appears on the cycle after ready rises.
REQ-034 SHALL check: start_i pulsed with a different key at idx5 -> the output sequence is unchanged versus the REQ-031 vector.
REQ-035 SHALL check: rst_n low at idx6 -> outputs go to 0 asynchronously with no done_o; a restart with the REQ-031 key reproduces idx1 correctly.
REQ-036 SHALL check: start_i high in the cycle after done_o -> a new expansion starts, and idx0 is valid on the following cycle.
